// File: rtl/async2fifo_pkg.sv
// rtl/async2fifo_pkg.sv - shared sizing constants for the show-ahead fifo
package async2fifo_pkg;

    localparam int WID_DEFAULT   = 32;
    localparam int DEPTH_DEFAULT = 16;
    localparam int ADDR_W        = $clog2(DEPTH_DEFAULT);

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/async2fifo_mem.sv
// rtl/async2fifo_mem.sv - fifo_mem storage array, sync write / async read
module fifo_mem
    import async2fifo_pkg::*;
#(
    parameter int WID   = WID_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = ADDR_W
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [WID-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [WID-1:0] rdata
);

    logic [WID-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async2fifo.sv
// rtl/async2fifo.sv - single-clock first-word-fall-through fifo with extra-MSB pointers
module async2fifo
    import async2fifo_pkg::*;
#(
    parameter int WID   = WID_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WID-1:0] wdata,
    input  logic           writex,
    output logic           wfull,
    input  logic           readx,
    output logic [WID-1:0] rdata,
    output logic           rempty
);

    localparam int AW = addr_width(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic           wr_acc;
    logic           rd_acc;
    logic [WID-1:0] mem_rdata;

    // The pointer MSB is a lap bit: equal low bits with differing laps means full.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign wr_acc = writex && !wfull;
    assign rd_acc = readx && !rempty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    fifo_mem #(
        .WID   (WID),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign rdata = rempty ? '0 : mem_rdata;

endmodule

// File: tb/tb_async2fifo.sv
// tb/tb_async2fifo.sv - self-checking bench for async2fifo
module tb_async2fifo;

    localparam int WID   = 32;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [WID-1:0] wdata = '0;
    logic           writex = 1'b0;
    logic           readx = 1'b0;
    logic           wfull;
    logic [WID-1:0] rdata;
    logic           rempty;

    int errors = 0;
    int checks = 0;

    logic [WID-1:0] q [$];

    typedef struct {
        bit             w;
        logic [WID-1:0] wd;
        bit             r;
        bit             exp_empty;
        bit             exp_full;
        logic [WID-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    async2fifo #(.WID(WID), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .writex (writex),
        .wfull  (wfull),
        .readx  (readx),
        .rdata  (rdata),
        .rempty (rempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the reference queue follows the accept rules.
    task automatic tick(input bit w, input logic [WID-1:0] wd, input bit r);
        bit wa;
        bit ra;
        writex = w;
        wdata  = wd;
        readx  = r;
        wa = w && (q.size() < DEPTH);
        ra = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(wd);
        writex = 1'b0;
        readx  = 1'b0;
    endtask

    task automatic chk_model(input string nm);
        logic [WID-1:0] exp_rd;
        exp_rd = (q.size() > 0) ? q[0] : '0;
        chk({nm, "_empty"}, {31'd0, rempty}, {31'd0, q.size() == 0});
        chk({nm, "_full"},  {31'd0, wfull},  {31'd0, q.size() == DEPTH});
        chk({nm, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        int n;
        logic [WID-1:0] tmp;

        vecs[0] = '{1, 32'h11, 0, 0, 0, 32'h11};
        vecs[1] = '{1, 32'h22, 0, 0, 0, 32'h11};
        vecs[2] = '{1, 32'h33, 0, 0, 0, 32'h11};
        vecs[3] = '{0, 32'h0,  1, 0, 0, 32'h22};
        vecs[4] = '{0, 32'h0,  1, 0, 0, 32'h33};
        vecs[5] = '{0, 32'h0,  1, 1, 0, 32'h0};
        vecs[6] = '{0, 32'h0,  1, 1, 0, 32'h0};
        vecs[7] = '{1, 32'h5A, 0, 0, 0, 32'h5A};
        vecs[8] = '{1, 32'h77, 1, 0, 0, 32'h77};
        vecs[9] = '{0, 32'h0,  1, 1, 0, 32'h0};

        #2;
        chk("reset_empty", {31'd0, rempty}, 32'd1);
        chk("reset_full",  {31'd0, wfull},  32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].w, vecs[i].wd, vecs[i].r);
            chk($sformatf("vec%0d_empty", i), {31'd0, rempty}, {31'd0, vecs[i].exp_empty});
            chk($sformatf("vec%0d_full", i),  {31'd0, wfull},  {31'd0, vecs[i].exp_full});
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Fill to capacity, then a rejected write of 0xDEAD.
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, i, 0);
        end
        chk("fill_full", {31'd0, wfull}, 32'd1);
        tick(1, 32'hDEAD, 0);
        chk("ovf_full",  {31'd0, wfull}, 32'd1);
        chk("ovf_rdata", rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), rdata, i);
            tick(0, 0, 1);
        end
        chk("drain_empty", {31'd0, rempty}, 32'd1);

        // Full with simultaneous write and read: only the read is taken.
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, i, 0);
        end
        tick(1, 32'hBEEF, 1);
        chk("wr_rd_full_wfull", {31'd0, wfull}, 32'd0);
        chk("wr_rd_full_head",  rdata, 32'd1);
        n = 0;
        while (!rempty && n < 20) begin
            tmp = rdata;
            chk($sformatf("beef_drain%0d", n), tmp, n + 1);
            tick(0, 0, 1);
            n++;
        end
        chk("wr_rd_full_occ", n, 32'd15);

        // Steady streaming at occupancy 3 across pointer wrap.
        for (int i = 0; i < 3; i++) begin
            tick(1, $urandom, 0);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1, $urandom, 1);
            chk_model($sformatf("stream%0d", i));
            chk($sformatf("stream%0d_occ", i), q.size(), 32'd3);
        end
        while (q.size() > 0) tick(0, 0, 1);
        chk_model("stream_end");

        // Randomised mix against the reference queue.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45);
            chk_model($sformatf("rand%0d", i));
        end

        // Fill 5, then reset between edges: flags must react immediately.
        while (q.size() > 0) tick(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 32'hA0 + i, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_empty", {31'd0, rempty}, 32'd1);
        chk("midrst_full",  {31'd0, wfull},  32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1, 32'h5A, 1);
        chk("postrst_rdata", rdata, 32'h5A);
        chk_model("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
